logic_op_selector: RTL
======================

// Module: logic_op_selector
// PURPOSE
//   Parametrised, registered successor to the fixed OR gate.
//   Each accepted beat applies one of eight bitwise ops to operands a/b, or to a running accumulator.
//   Results are buffered in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
//   Sits between the pad-facing input registers and downstream consumers in the tile top level.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=1)
//   DEPTH  4  output FIFO entries (power of two, >=2)
// PORTS
//   clk        in   1                  rising-edge clock; single clock domain
//   rst        in   1                  synchronous reset, active-high
//   in_valid   in   1                  operand beat present
//   in_ready   out  1                  block can accept a beat this cycle
//   a          in   WIDTH              operand A
//   b          in   WIDTH              operand B
//   op         in   3                  operation select, sampled with the beat
//   acc_clr    in   1                  synchronous clear of accumulator to 0
//   out_valid  out  1                  FIFO head valid
//   out_ready  in   1                  consumer takes head this cycle
//   result     out  WIDTH              FIFO head data
//   count      out  $clog2(DEPTH)+1    FIFO occupancy
// BEHAVIOUR
//   - Reset: FIFO empty, count=0, out_valid=0, result=0, acc=0, in_ready=1 the cycle after rst deasserts.
//   - Accept = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready = (count < DEPTH). A pop in the same cycle does not free space early (no bypass).
//   - op encoding:
//       0 OR, 1 AND, 2 XOR, 3 NAND, 4 NOR: result = a op b; acc unchanged.
//       5 ACC_LOAD: acc <= a, result = a.
//       6 ACC_OR: acc <= acc|a, result = acc|a.
//       7 ACC_AND: acc <= acc&a, result = acc&a.
//       b is ignored for ops 5-7.
//   - acc updates only on an accepted beat. No beat means no change.
//   - acc_clr has priority over the ACC update in the same cycle: acc <= 0.
//     The beat's result is still computed with the pre-clear acc.
//   - Latency: an accepted beat into an empty FIFO gives out_valid=1 the next cycle, with result valid then.
//   - Ordering is strict FIFO. Pointers wrap mod DEPTH.
//   - Push and pop in the same cycle: count unchanged.
//   - Push when full: cannot occur, because in_ready=0.
//   - Pop when empty: ignored, and count never underflows.
//   - result holds the current head. When the FIFO is empty, result holds its last value, or 0 after reset.
//   - rst mid-stream: FIFO contents discarded, acc=0, count=0 on the next edge.
//     In-flight beats are dropped.
// CONFIGURATION
//   LOGIC_SEL_POPCOUNT_EN defined:
//     - Extra port pop_cnt (out, $clog2(WIDTH+1)) = number of 1s in result.
//     - pop_cnt is stored in the FIFO with the result and presented with the same head entry.
//     - Reset value 0.
//   LOGIC_SEL_POPCOUNT_EN undefined: the port is absent and no popcount logic is built.
// STRUCTURE
//   - Shared package logic_sel_pkg:
//       op enum/localparams (OP_OR..OP_ACC_AND);
//       function apply_op(op, a, b, acc) returning the result.
//   - Sub-module logic_sel_fifo (WIDTH, DEPTH): sync FIFO with push/pop/full/empty/count.
//     It is reused for the popcount-extended entry width.
//   - Top level holds the accumulator, the handshake logic and the op datapath.
// TESTING
//   1. Reset, then a=8'hF0, b=8'h0F, ops 0-4 with out_ready=1.
//      -> results FF, 00, FF, FF, 00, each 1 cycle after accept.
//   2. op5 a=8'h81, then op6 a=8'h18, then op7 a=8'h09.
//      -> results 81, 99, 09.
//   3. Hold out_ready=0 and offer 6 beats.
//      -> 4 accepted, in_ready=0 at count=4, then in_ready=1 one cycle after the first pop.
//   4. FIFO at count=2, push and pop in the same cycle.
//      -> count stays 2 and order is preserved across pointer wrap.
//   5. acc_clr with an op6 beat a=8'h01 while acc=8'h10.
//      -> result 11, acc=0 next cycle.
//   6. rst asserted with count=3.
//      -> next cycle count=0, out_valid=0, result=0, acc=0.
//      With LOGIC_SEL_POPCOUNT_EN, result FF gives pop_cnt=8.

Source files
------------

// File: rtl/logic_sel_pkg.sv
// Shared definitions for logic_op_selector: operation encoding and the
// per-beat result function. Optional feature macro: LOGIC_SEL_POPCOUNT_EN.
package logic_sel_pkg;

  // Widest operand apply_op can process; callers zero-extend and truncate.
  localparam int unsigned OP_MAX_W = 64;

  typedef logic [OP_MAX_W-1:0] op_word_t;

  typedef enum logic [2:0] {
    OP_OR       = 3'd0,
    OP_AND      = 3'd1,
    OP_XOR      = 3'd2,
    OP_NAND     = 3'd3,
    OP_NOR      = 3'd4,
    OP_ACC_LOAD = 3'd5,
    OP_ACC_OR   = 3'd6,
    OP_ACC_AND  = 3'd7
  } op_e;

  // Result of one beat. For the accumulator ops the same value is also the
  // accumulator's next value. Bits above the caller's width are don't-care.
  function automatic op_word_t apply_op(op_e op, op_word_t a, op_word_t b, op_word_t acc);
    op_word_t r;
    r = '0;
    case (op)
      OP_OR:       r = a | b;
      OP_AND:      r = a & b;
      OP_XOR:      r = a ^ b;
      OP_NAND:     r = ~(a & b);
      OP_NOR:      r = ~(a | b);
      OP_ACC_LOAD: r = a;
      OP_ACC_OR:   r = acc | a;
      OP_ACC_AND:  r = acc & a;
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_sel_fifo.sv
// Synchronous FIFO with occupancy count. rdata_o shows the head entry and,
// while empty, keeps showing the most recently popped entry (0 after reset).
module logic_sel_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import logic_sel_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] hold_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign count_o = count_q;
  assign rdata_o = empty_o ? hold_q : mem_q[rd_ptr_q];

  // Occupancy next state; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers (wrap naturally, DEPTH is a power of two), count and hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/logic_op_selector.sv
// Registered bitwise-op selector with accumulator and DEPTH-entry output FIFO.
// Optional feature macro: LOGIC_SEL_POPCOUNT_EN adds pop_cnt, carried through
// the FIFO alongside each result. WIDTH is limited to 64 bits.
module logic_op_selector #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [2:0]                 op,
  input  logic                       acc_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result,
`ifdef LOGIC_SEL_POPCOUNT_EN
  output logic [$clog2(WIDTH+1)-1:0] pop_cnt,
`endif
  output logic [$clog2(DEPTH):0]     count
);
  import logic_sel_pkg::*;

`ifdef LOGIC_SEL_POPCOUNT_EN
  localparam int unsigned PCW = $clog2(WIDTH+1);
  localparam int unsigned EW  = WIDTH + PCW;
`else
  localparam int unsigned EW  = WIDTH;
`endif

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res;
  logic             accept, pop, full, empty;
  logic [EW-1:0]    entry_in, entry_out;
  op_e              op_sel;

  assign op_sel    = op_e'(op);
  assign res       = WIDTH'(apply_op(op_sel, op_word_t'(a), op_word_t'(b), op_word_t'(acc_q)));
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef LOGIC_SEL_POPCOUNT_EN
  logic [PCW-1:0] res_pc;

  // Number of set bits in this beat's result.
  always_comb begin
    res_pc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) res_pc = res_pc + PCW'(res[i]);
  end

  assign entry_in = {res_pc, res};
  assign pop_cnt  = entry_out[EW-1:WIDTH];
`else
  assign entry_in = res;
`endif

  assign result = entry_out[WIDTH-1:0];

  // Accumulator next state: clear wins; the beat's result used the old value.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (accept && (op_sel inside {OP_ACC_LOAD, OP_ACC_OR, OP_ACC_AND})) begin
      acc_d = res;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  logic_sel_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (entry_in),
    .rdata_o (entry_out),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule
